// File: rtl/scope_fifo_pkg.sv
// Shared constants and read-mode type for the scope sync FIFO slice.
// Default parameter values live here so the top and the RAM agree on them.
package scope_fifo_pkg;

  localparam int DEF_DATA_WIDTH       = 32;
  localparam int DEF_DEPTH_WIDTH      = 8;
  localparam int DEF_ALMOST_FULL_NUM  = 252;
  localparam int DEF_ALMOST_EMPTY_NUM = 4;

  typedef enum logic {
    STD  = 1'b0,
    FWFT = 1'b1
  } read_mode_e;

  // Maps the legacy integer FWFT parameter onto the read-mode enumeration.
  function automatic read_mode_e mode_from_param(input int fwft);
    return (fwft != 0) ? FWFT : STD;
  endfunction

endpackage

// File: rtl/scope_fifo_ram.sv
// Simple dual-port storage: one write port, one synchronous read port.
// Read data is registered and holds its value when rd_en is low.
module scope_fifo_ram
  import scope_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_DEPTH_WIDTH
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

  // NOTE: storage has no reset so it maps onto block RAM; the controller never reads an unwritten slot.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/scope_sync_fifo.sv
// Single-clock FIFO with level counter, threshold flags and optional
// first-word-fall-through output stage in front of a synchronous-read RAM.
module scope_sync_fifo #(
  parameter int DATA_WIDTH       = scope_fifo_pkg::DEF_DATA_WIDTH,
  parameter int DEPTH_WIDTH      = scope_fifo_pkg::DEF_DEPTH_WIDTH,
  parameter int FWFT             = 0,
  parameter int ALMOST_FULL_NUM  = scope_fifo_pkg::DEF_ALMOST_FULL_NUM,
  parameter int ALMOST_EMPTY_NUM = scope_fifo_pkg::DEF_ALMOST_EMPTY_NUM
) (
  input  logic                   clk,
  input  logic                   tb_rst,
  input  logic                   wr_en,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  output logic                   wr_full,
  output logic                   almost_full,
  output logic                   wr_overflow,
  input  logic                   rd_en,
  output logic [DATA_WIDTH-1:0]  rd_data,
  output logic                   rd_valid,
  output logic                   rd_empty,
  output logic                   almost_empty,
  output logic                   rd_underflow,
  output logic [DEPTH_WIDTH:0]   water_level
);

  localparam scope_fifo_pkg::read_mode_e MODE = scope_fifo_pkg::mode_from_param(FWFT);

  localparam logic [DEPTH_WIDTH:0]   FULL_LEVEL = {1'b1, {DEPTH_WIDTH{1'b0}}};
  localparam logic [DEPTH_WIDTH:0]   AF_LEVEL   = (DEPTH_WIDTH+1)'(ALMOST_FULL_NUM);
  localparam logic [DEPTH_WIDTH:0]   AE_LEVEL   = (DEPTH_WIDTH+1)'(ALMOST_EMPTY_NUM);
  localparam logic [DEPTH_WIDTH:0]   LVL_ONE    = (DEPTH_WIDTH+1)'(1);
  localparam logic [DEPTH_WIDTH-1:0] PTR_ONE    = DEPTH_WIDTH'(1);

  logic [DEPTH_WIDTH-1:0] wr_ptr;
  logic [DEPTH_WIDTH-1:0] rd_ptr;
  logic                   wr_accept;
  logic                   rd_accept;
  logic                   ram_rd_en;
  logic [DATA_WIDTH-1:0]  ram_q;

  assign wr_full      = (water_level == FULL_LEVEL);
  assign almost_full  = (water_level >= AF_LEVEL);
  assign almost_empty = (water_level <= AE_LEVEL);
  assign wr_accept    = wr_en && !wr_full;
  assign rd_accept    = rd_en && !rd_empty;

  scope_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (DEPTH_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_en   (ram_rd_en),
    .rd_addr (rd_ptr),
    .rd_data (ram_q)
  );

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      water_level  <= '0;
      wr_overflow  <= 1'b0;
      rd_underflow <= 1'b0;
    end else begin
      wr_overflow  <= wr_en && wr_full;
      rd_underflow <= rd_en && rd_empty;
      if (wr_accept) wr_ptr <= wr_ptr + PTR_ONE;
      if (ram_rd_en) rd_ptr <= rd_ptr + PTR_ONE;
      if (wr_accept && !rd_accept)      water_level <= water_level + LVL_ONE;
      else if (rd_accept && !wr_accept) water_level <= water_level - LVL_ONE;
    end
  end

  if (MODE == scope_fifo_pkg::FWFT) begin : g_fwft
    // Words leave the RAM into a pending slot (the RAM output register) and
    // then into the head register; fetching is allowed whenever the pending
    // slot is free or is moving to the head on this edge, so pops never bubble.
    logic [DEPTH_WIDTH:0]  ram_cnt;
    logic                  pending;
    logic                  head_valid;
    logic                  head_load;
    logic [DATA_WIDTH-1:0] head_data;

    assign head_load = pending && (!head_valid || rd_accept);
    assign ram_rd_en = (ram_cnt != '0) && (!pending || head_load);
    assign rd_empty  = !head_valid;
    assign rd_valid  = head_valid;
    assign rd_data   = head_data;

    always_ff @(posedge clk or posedge tb_rst) begin
      if (tb_rst) begin
        ram_cnt    <= '0;
        pending    <= 1'b0;
        head_valid <= 1'b0;
        head_data  <= '0;
      end else begin
        if (wr_accept && !ram_rd_en)      ram_cnt <= ram_cnt + LVL_ONE;
        else if (ram_rd_en && !wr_accept) ram_cnt <= ram_cnt - LVL_ONE;
        pending <= ram_rd_en || (pending && !head_load);
        if (head_load) begin
          head_data  <= ram_q;
          head_valid <= 1'b1;
        end else if (rd_accept) begin
          head_valid <= 1'b0;
        end
      end
    end
  end else begin : g_std
    // The RAM output register is the read port; it shows zero until the
    // first read after reset because the RAM itself is never cleared.
    logic loaded;
    logic valid_q;

    assign ram_rd_en = rd_accept;
    assign rd_empty  = (water_level == '0);
    assign rd_valid  = valid_q;
    assign rd_data   = loaded ? ram_q : '0;

    always_ff @(posedge clk or posedge tb_rst) begin
      if (tb_rst) begin
        loaded  <= 1'b0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_accept;
        if (rd_accept) loaded <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_scope_sync_fifo.sv
// Scoreboard bench: one standard-mode and one FWFT instance share stimulus;
// queue-based reference models predict every output each cycle.
module tb_scope_sync_fifo;

  localparam int DEPTH = 256;

  typedef struct {
    logic [31:0] data;
    int unsigned wr_edge;
  } word_t;

  logic        clk     = 1'b0;
  logic        tb_rst  = 1'b0;
  logic        wr_en   = 1'b0;
  logic [31:0] wr_data = '0;
  logic        rd_en   = 1'b0;

  logic        s_full, s_afull, s_ovf, s_rd_valid, s_empty, s_aempty, s_unf;
  logic [31:0] s_rd_data;
  logic [8:0]  s_level;
  logic        f_full, f_afull, f_ovf, f_rd_valid, f_empty, f_aempty, f_unf;
  logic [31:0] f_rd_data;
  logic [8:0]  f_level;

  always #5 clk = ~clk;

  scope_sync_fifo #(.DATA_WIDTH(32), .DEPTH_WIDTH(8), .FWFT(0),
                    .ALMOST_FULL_NUM(252), .ALMOST_EMPTY_NUM(4)) u_std (
    .clk(clk), .tb_rst(tb_rst), .wr_en(wr_en), .wr_data(wr_data),
    .wr_full(s_full), .almost_full(s_afull), .wr_overflow(s_ovf),
    .rd_en(rd_en), .rd_data(s_rd_data), .rd_valid(s_rd_valid), .rd_empty(s_empty),
    .almost_empty(s_aempty), .rd_underflow(s_unf), .water_level(s_level)
  );

  scope_sync_fifo #(.DATA_WIDTH(32), .DEPTH_WIDTH(8), .FWFT(1),
                    .ALMOST_FULL_NUM(252), .ALMOST_EMPTY_NUM(4)) u_fwft (
    .clk(clk), .tb_rst(tb_rst), .wr_en(wr_en), .wr_data(wr_data),
    .wr_full(f_full), .almost_full(f_afull), .wr_overflow(f_ovf),
    .rd_en(rd_en), .rd_data(f_rd_data), .rd_valid(f_rd_valid), .rd_empty(f_empty),
    .almost_empty(f_aempty), .rd_underflow(f_unf), .water_level(f_level)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] sq[$];      // standard-mode contents
  logic [31:0] exp_rd[$];  // standard-mode words due on rd_data next negedge
  word_t       fq[$];      // FWFT contents with the edge each word was written
  logic        exp_ovf_s = 1'b0, exp_unf_s = 1'b0;
  logic        exp_ovf_f = 1'b0, exp_unf_f = 1'b0;
  int unsigned edge_n = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // A FWFT word becomes readable two edges after the edge that wrote it,
  // and never before the words ahead of it have been popped.
  function automatic bit head_visible();
    return (fq.size() > 0) && (edge_n >= fq[0].wr_edge + 2);
  endfunction

  task automatic cycle(input logic we, input logic [31:0] wd, input logic re);
    bit    s_wacc, s_racc, f_wacc, f_racc;
    word_t w;
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    s_wacc = we && (sq.size() < DEPTH);
    s_racc = re && (sq.size() > 0);
    f_wacc = we && (fq.size() < DEPTH);
    f_racc = re && head_visible();
    @(posedge clk);
    edge_n++;
    #2;
    if (s_racc) exp_rd.push_back(sq.pop_front());
    if (s_wacc) sq.push_back(wd);
    exp_ovf_s = we && !s_wacc;
    exp_unf_s = re && !s_racc;
    if (f_racc) w = fq.pop_front();
    if (f_wacc) begin
      w.data    = wd;
      w.wr_edge = edge_n;
      fq.push_back(w);
    end
    exp_ovf_f = we && !f_wacc;
    exp_unf_f = re && !f_racc;
  endtask

  task automatic check_reset(input string tag);
    check({tag, " s_full"},   s_full, 0);     check({tag, " f_full"},   f_full, 0);
    check({tag, " s_afull"},  s_afull, 0);    check({tag, " f_afull"},  f_afull, 0);
    check({tag, " s_ovf"},    s_ovf, 0);      check({tag, " f_ovf"},    f_ovf, 0);
    check({tag, " s_data"},   s_rd_data, 0);  check({tag, " f_data"},   f_rd_data, 0);
    check({tag, " s_valid"},  s_rd_valid, 0); check({tag, " f_valid"},  f_rd_valid, 0);
    check({tag, " s_empty"},  s_empty, 1);    check({tag, " f_empty"},  f_empty, 1);
    check({tag, " s_aempty"}, s_aempty, 1);   check({tag, " f_aempty"}, f_aempty, 1);
    check({tag, " s_unf"},    s_unf, 0);      check({tag, " f_unf"},    f_unf, 0);
    check({tag, " s_level"},  s_level, 0);    check({tag, " f_level"},  f_level, 0);
  endtask

  // Monitor: compares every output of both instances against the models.
  initial begin
    logic [31:0] e;
    bit          vis;
    forever begin
      @(negedge clk);
      check("s_level",  s_level,  sq.size());
      check("s_full",   s_full,   sq.size() == DEPTH);
      check("s_afull",  s_afull,  sq.size() >= 252);
      check("s_aempty", s_aempty, sq.size() <= 4);
      check("s_empty",  s_empty,  sq.size() == 0);
      check("s_ovf",    s_ovf,    exp_ovf_s);
      check("s_unf",    s_unf,    exp_unf_s);
      if (exp_rd.size() > 0) begin
        e = exp_rd.pop_front();
        check("s_rd_valid", s_rd_valid, 1);
        check("s_rd_data",  s_rd_data,  e);
      end else begin
        check("s_rd_valid", s_rd_valid, 0);
      end
      vis = head_visible();
      check("f_level",    f_level,    fq.size());
      check("f_full",     f_full,     fq.size() == DEPTH);
      check("f_afull",    f_afull,    fq.size() >= 252);
      check("f_aempty",   f_aempty,   fq.size() <= 4);
      check("f_ovf",      f_ovf,      exp_ovf_f);
      check("f_unf",      f_unf,      exp_unf_f);
      check("f_rd_valid", f_rd_valid, vis);
      check("f_empty",    f_empty,    !vis);
      if (vis) check("f_rd_data", f_rd_data, fq[0].data);
    end
  end

  initial begin
    int pw[4] = '{70, 30, 90, 10};
    #1 tb_rst = 1'b1;
    #1 check_reset("init");
    @(posedge clk);
    #2 tb_rst = 1'b0;

    // Fill standard and FWFT to full with descending data, then overflow.
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 32'hFFFF_FFFF - 32'(i), 1'b0);
      if (i == 250) check("afull_251", s_afull, 0);
      if (i == 251) check("afull_252", s_afull, 1);
    end
    check("fill s_full", s_full, 1);
    check("fill s_level", s_level, 256);
    check("fill f_full", f_full, 1);
    cycle(1'b1, 32'hDEAD_BEEF, 1'b0);
    check("ovf pulse", s_ovf, 1);
    check("ovf level", s_level, 256);
    cycle(1'b0, '0, 1'b0);
    check("ovf cleared", s_ovf, 0);

    // Drain in order, then one read past empty.
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, '0, 1'b1);
      if (i == 0)   check("first rd_data", s_rd_data, 32'hFFFF_FFFF);
      if (i == 255) check("last rd_data",  s_rd_data, 32'hFFFF_FF00);
    end
    check("drain s_empty", s_empty, 1);
    cycle(1'b0, '0, 1'b1);
    check("unf s", s_unf, 1);
    check("unf f", f_unf, 1);

    // FWFT fall-through latency on a single word.
    cycle(1'b1, 32'h1234_5678, 1'b0);
    check("fwft e+0 empty", f_empty, 1);
    cycle(1'b0, '0, 1'b0);
    check("fwft e+1 empty", f_empty, 1);
    cycle(1'b0, '0, 1'b0);
    check("fwft e+2 empty", f_empty, 0);
    check("fwft e+2 data", f_rd_data, 32'h1234_5678);
    cycle(1'b0, '0, 1'b1);
    check("fwft pop empty", f_empty, 1);

    // Steady state at level 100 with simultaneous traffic across pointer wrap.
    for (int i = 0; i < 100; i++) cycle(1'b1, $urandom, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0);
    for (int i = 0; i < 300; i++) cycle(1'b1, $urandom, 1'b1);
    check("steady s_level", s_level, 100);
    check("steady f_level", f_level, 100);

    // Randomised traffic with write bias varying to reach full and empty.
    for (int seg = 0; seg < 4; seg++)
      for (int i = 0; i < 500; i++)
        cycle($urandom_range(0, 99) < pw[seg], $urandom, $urandom_range(0, 99) < (100 - pw[seg]));

    // Drain, refill to 50, then reset asynchronously mid-operation.
    for (int i = 0; i < 1000; i++) begin
      if (sq.size() == 0 && fq.size() == 0) break;
      cycle(1'b0, '0, 1'b1);
    end
    for (int i = 0; i < 50; i++) cycle(1'b1, $urandom, 1'b0);
    check("pre-reset s_level", s_level, 50);
    check("pre-reset f_level", f_level, 50);
    tb_rst = 1'b1;
    #1 check_reset("mid");
    sq.delete();
    exp_rd.delete();
    fq.delete();
    exp_ovf_s = 1'b0; exp_unf_s = 1'b0;
    exp_ovf_f = 1'b0; exp_unf_f = 1'b0;
    #1 tb_rst = 1'b0;

    cycle(1'b1, 32'hA5A5_A5A5, 1'b0);
    cycle(1'b0, '0, 1'b1);
    check("post-reset s_valid", s_rd_valid, 1);
    check("post-reset s_data", s_rd_data, 32'hA5A5_A5A5);
    cycle(1'b0, '0, 1'b1);
    check("post-reset f_empty", f_empty, 0);
    check("post-reset f_data", f_rd_data, 32'hA5A5_A5A5);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);
    check("post-reset f_drained", f_empty, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scope_sync_fifo.md
SCOPE_SYNC_FIFO -- requirements
Module: scope_sync_fifo

Interface
REQ-001 Parameter DATA_WIDTH, 32, word width in bits (1..1152).
REQ-002 Parameter DEPTH_WIDTH, 8, log2 of depth; depth = 2**DEPTH_WIDTH (4..20).
REQ-003 Parameter FWFT, 0, 1 = first-word-fall-through read mode, 0 = standard read mode.
REQ-004 Parameter ALMOST_FULL_NUM, 252, almost_full threshold in words.
REQ-005 Parameter ALMOST_EMPTY_NUM, 4, almost_empty threshold in words.
REQ-006 clk  input  1  single clock for both ports.
REQ-007 tb_rst  input  1  reset, asynchronous, active-high.
REQ-008 wr_en  input  1  write request.
REQ-009 wr_data  input  DATA_WIDTH  write word.
REQ-010 wr_full  output  1  FIFO holds depth words.
REQ-011 almost_full  output  1  level >= ALMOST_FULL_NUM.
REQ-012 wr_overflow  output  1  one-cycle pulse: write request rejected.
REQ-013 rd_en  input  1  read request (pop).
REQ-014 rd_data  output  DATA_WIDTH  read word.
REQ-015 rd_valid  output  1  rd_data holds a newly popped word (standard mode) or a valid head word (FWFT).
REQ-016 rd_empty  output  1  no word available to read.
REQ-017 almost_empty  output  1  level <= ALMOST_EMPTY_NUM.
REQ-018 rd_underflow  output  1  one-cycle pulse: read request rejected.
REQ-019 water_level  output  DEPTH_WIDTH+1  words stored, 0..depth.

Function
REQ-020 Write accepted on a clk edge when wr_en=1 and wr_full=0; wr_en=1 with wr_full=1 discards the word and pulses wr_overflow the next cycle.
REQ-021 A read is accepted when rd_en=1 and rd_empty=0; rd_en=1 with rd_empty=1 pulses rd_underflow the next cycle and changes no state.
REQ-022 Simultaneous accepted read and write leave water_level unchanged; at full, a write with a concurrent read is still rejected; at empty, a read with a concurrent write is still rejected.
REQ-023 water_level is a registered count, updated on the edge that accepts the operation; wr_full, almost_full, almost_empty derive combinationally from it.
REQ-024 Write and read pointers are DEPTH_WIDTH bits and wrap from depth-1 to 0 without special handling.
REQ-025 Standard mode: rd_empty = (water_level == 0); rd_data updates exactly 1 cycle after the accepting edge with rd_valid=1 for that one cycle; otherwise rd_data holds its last value.
REQ-026 FWFT mode: head word is prefetched into an output register; rd_empty deasserts 2 cycles after the edge writing into an empty FIFO; rd_valid = !rd_empty; rd_en pops the head and the next word appears the following cycle without a bubble if stored.
REQ-027 FWFT water_level counts words in RAM plus the prefetch register.
REQ-028 Data order is strictly first-in first-out; no word is duplicated or dropped except rejected writes.

Reset
REQ-029 tb_rst=1 asynchronously clears pointers, water_level, prefetch state; wr_full=0, almost_full=0, wr_overflow=0, rd_data=0, rd_valid=0, rd_empty=1, almost_empty=1, rd_underflow=0.
REQ-030 RAM contents are not reset; reset mid-operation discards all stored words.
REQ-031 Deassertion of tb_rst is not synchronised internally; first operation is accepted on the first clk edge after deassertion.

Structure
REQ-032 Shared package scope_fifo_pkg holds default width/depth/threshold constants and the read-mode enumeration (STD, FWFT).
REQ-033 Storage is one sub-module scope_fifo_ram: simple dual-port RAM, 1 write port, 1 synchronous-read port, no reset.
REQ-034 Control, level counter, flags and FWFT prefetch reside in scope_sync_fifo.

Verification (DATA_WIDTH=32, DEPTH_WIDTH=8)
REQ-035 Standard mode, 256 writes of descending data from 0xFFFFFFFF -> wr_full=1 after 256th edge, water_level=256, almost_full set after 252nd; 257th write -> wr_overflow pulse, level stays 256.
REQ-036 Drain 256 reads -> rd_data 0xFFFFFFFF..0xFFFFFF00 in order, each 1 cycle after its rd_en, rd_empty=1 after last; extra read -> rd_underflow pulse.
REQ-037 FWFT: single write 0x12345678 into empty -> rd_empty=0 and rd_data=0x12345678 2 cycles later without rd_en; rd_en for one cycle -> rd_empty=1 next cycle.
REQ-038 Level 100, simultaneous wr_en/rd_en for 300 cycles -> water_level constant 100, pointers wrap, data order preserved.
REQ-039 tb_rst asserted mid-fill at level 50 -> all outputs at reset values immediately; subsequent write/read of 0xA5A5A5A5 returns 0xA5A5A5A5.
